// File: rtl/mix_scheduler.sv
// mix_scheduler: time-shares one MIX datapath across NUM_VOICES voices.
//
// On an accepted START, every voice's ENV/DC/MUL is snapshotted. One voice per
// cycle is then issued to the MIX operand registers. Each MIX result is
// captured into a shadow buffer, and the whole frame is committed to DC_OUT on
// one edge. Downstream PWM generators therefore never see a half-updated frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   START        sweep request, sampled only while BUSY=0
//   ENV_IN       per-voice envelope (7 bits/voice, voice v at [7v+6:7v])
//   DC_IN        per-voice base duty cycle (PWM_DEPTH bits/voice)
//   MUL_IN       per-voice envelope multiplier (5 bits/voice)
//   MIX_ENV      ENV operand to MIX (0 when idle)
//   MIX_DC_PRE   DC_PRE operand to MIX (0 when idle)
//   MIX_MUL      MUL operand to MIX (0 when idle)
//   MIX_DC_POST  result from MIX, valid MIX_LATENCY edges after operands
//   DC_OUT       committed per-voice duty cycles (DATAWIDTH bits/voice)
//   BUSY         sweep in progress
//   DONE         one-cycle pulse, DC_OUT updated this cycle
module mix_scheduler #(
    parameter int unsigned NUM_VOICES  = 4,
    parameter int unsigned MIX_LATENCY = 3,
    parameter int unsigned PWM_DEPTH   = 8,
    parameter int unsigned DATAWIDTH   = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            START,
    input  logic [7*NUM_VOICES-1:0]         ENV_IN,
    input  logic [PWM_DEPTH*NUM_VOICES-1:0] DC_IN,
    input  logic [5*NUM_VOICES-1:0]         MUL_IN,
    output logic [6:0]                      MIX_ENV,
    output logic [PWM_DEPTH-1:0]            MIX_DC_PRE,
    output logic [4:0]                      MIX_MUL,
    input  logic [DATAWIDTH-1:0]            MIX_DC_POST,
    output logic [DATAWIDTH*NUM_VOICES-1:0] DC_OUT,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StCommit
    } state_t;

    state_t state_q, state_d;

    logic [NUM_VOICES-1:0][6:0]           env_snap_q;
    logic [NUM_VOICES-1:0][PWM_DEPTH-1:0] dc_snap_q;
    logic [NUM_VOICES-1:0][4:0]           mul_snap_q;
    logic [IDX_W-1:0]                     issue_cnt_q;

    // Delay line tracking which voice's result arrives on MIX_DC_POST.
    logic [MIX_LATENCY-1:0]            pipe_vld_q;
    logic [MIX_LATENCY-1:0][IDX_W-1:0] pipe_idx_q;

    logic [NUM_VOICES-1:0][DATAWIDTH-1:0] shadow_q;
    logic [NUM_VOICES-1:0][DATAWIDTH-1:0] dc_out_q;

    logic [6:0]           mix_env_q;
    logic [PWM_DEPTH-1:0] mix_dc_pre_q;
    logic [4:0]           mix_mul_q;
    logic                 busy_q;
    logic                 done_q;

    logic accept;
    logic issuing;
    logic capture;
    logic last_capture;

    // BUSY is low exactly when the FSM is idle, so START is only seen here.
    assign accept       = (state_q == StIdle) && START;
    assign issuing      = (state_q == StIssue);
    assign capture      = pipe_vld_q[MIX_LATENCY-1];
    assign last_capture = capture && (pipe_idx_q[MIX_LATENCY-1] == LAST_IDX);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (START) state_d = StIssue;
            StIssue:  if (issue_cnt_q == LAST_IDX) state_d = StDrain;
            StDrain:  if (last_capture) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Snapshot and issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_snap_q  <= '0;
            dc_snap_q   <= '0;
            mul_snap_q  <= '0;
            issue_cnt_q <= '0;
        end else if (accept) begin
            env_snap_q  <= ENV_IN;
            dc_snap_q   <= DC_IN;
            mul_snap_q  <= MUL_IN;
            issue_cnt_q <= '0;
        end else if (issuing) begin
            issue_cnt_q <= issue_cnt_q + IDX_W'(1);
        end
    end

    // MIX operand registers: zero whenever no voice is being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_env_q    <= '0;
            mix_dc_pre_q <= '0;
            mix_mul_q    <= '0;
        end else if (issuing) begin
            mix_env_q    <= env_snap_q[issue_cnt_q];
            mix_dc_pre_q <= dc_snap_q[issue_cnt_q];
            mix_mul_q    <= mul_snap_q[issue_cnt_q];
        end else begin
            mix_env_q    <= '0;
            mix_dc_pre_q <= '0;
            mix_mul_q    <= '0;
        end
    end

    // Result delay line: stage 0 loads alongside the operand registers, so the
    // last stage lines up with the edge where MIX_DC_POST is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            pipe_vld_q[0] <= issuing;
            pipe_idx_q[0] <= issue_cnt_q;
            for (int k = 1; k < int'(MIX_LATENCY); k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end
        end
    end

    // Shadow buffer: results stored bit-exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (capture) begin
            shadow_q[pipe_idx_q[MIX_LATENCY-1]] <= MIX_DC_POST;
        end
    end

    // Commit, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == StCommit);
            if (state_q == StCommit) begin
                dc_out_q <= shadow_q;
                busy_q   <= 1'b0;
            end else if (accept) begin
                busy_q   <= 1'b1;
            end
        end
    end

    assign MIX_ENV    = mix_env_q;
    assign MIX_DC_PRE = mix_dc_pre_q;
    assign MIX_MUL    = mix_mul_q;
    assign DC_OUT     = dc_out_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// Self-checking bench for mix_scheduler with a behavioural MIX unit
// (DC_POST = min(DC_PRE + ENV*MUL, 4095), three-edge latency).
module tb_mix_scheduler;

    localparam int N     = 4;
    localparam int L     = 3;
    localparam int SWEEP = N + L + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [27:0] env_in = '0;
    logic [31:0] dc_in = '0;
    logic [19:0] mul_in = '0;
    logic [6:0]  mix_env;
    logic [7:0]  mix_dc_pre;
    logic [4:0]  mix_mul;
    logic [11:0] mix_dc_post;
    logic [47:0] dc_out;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mix_scheduler #(
        .NUM_VOICES (N),
        .MIX_LATENCY(L),
        .PWM_DEPTH  (8),
        .DATAWIDTH  (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .START      (start),
        .ENV_IN     (env_in),
        .DC_IN      (dc_in),
        .MUL_IN     (mul_in),
        .MIX_ENV    (mix_env),
        .MIX_DC_PRE (mix_dc_pre),
        .MIX_MUL    (mix_mul),
        .MIX_DC_POST(mix_dc_post),
        .DC_OUT     (dc_out),
        .BUSY       (busy),
        .DONE       (done)
    );

    // MIX model: combinational result followed by L-1 registers.
    logic [12:0] mix_sum;
    logic [11:0] mix_p1, mix_p2;
    assign mix_sum = 13'(mix_dc_pre) + 13'(mix_env) * 13'(mix_mul);
    always @(posedge clk) begin
        mix_p1 <= (mix_sum > 13'd4095) ? 12'd4095 : mix_sum[11:0];
        mix_p2 <= mix_p1;
    end
    assign mix_dc_post = mix_p2;

    typedef struct packed {
        logic [27:0] env_pre;
        logic [31:0] dc_pre;
        logic [19:0] mul_pre;
        logic [27:0] env_post;
        logic [31:0] dc_post;
        logic [19:0] mul_post;
        logic [47:0] exp_out;
        logic        repulse;
    } vec_t;

    function automatic logic [27:0] e4(int a, int b, int c, int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction
    function automatic logic [31:0] d4(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction
    function automatic logic [19:0] m4(int a, int b, int c, int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction
    function automatic logic [47:0] o4(int a, int b, int c, int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One full sweep: inputs switch to the *_post values right after the START edge.
    task automatic run_sweep(input vec_t v, input logic [47:0] prev_out);
        int n;
        int extra;
        bit busy_ok, hold_ok, mix_ok;
        @(negedge clk);
        env_in = v.env_pre; dc_in = v.dc_pre; mul_in = v.mul_pre;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        env_in = v.env_post; dc_in = v.dc_post; mul_in = v.mul_post;
        n = 0; busy_ok = 1; hold_ok = 1; mix_ok = 1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 0;
            if (dc_out !== prev_out) hold_ok = 0;
            if (n == 1 && (mix_env !== v.env_pre[6:0] || mix_mul !== v.mul_pre[4:0])) mix_ok = 0;
            if (n == N && mix_dc_pre !== v.dc_pre[31:24]) mix_ok = 0;
            if (n == N + 1 && {mix_env, mix_dc_pre, mix_mul} !== 20'd0) mix_ok = 0;
            @(negedge clk);
            n++;
            start = (v.repulse && n == 2);
        end
        start = 1'b0;
        check("done_latency", n, SWEEP);
        check("busy_during_sweep", busy_ok, 1);
        check("dc_out_hold", hold_ok, 1);
        check("mix_operands", mix_ok, 1);
        check("dc_out_commit", dc_out, v.exp_out);
        check("busy_at_done", busy, 0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("single_done", extra, 0);
    endtask

    task automatic wait_done(output int c, output bit ok);
        int k = 0;
        ok = 0;
        c  = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (done) begin
                ok = 1;
                c  = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [47:0] last_out;
        int c0, c1, c2;
        bit ok;

        vecs[0] = '{e4(2, 10, 0, 1), d4(5, 100, 255, 0), m4(4, 3, 31, 1),
                    e4(2, 10, 0, 1), d4(5, 100, 255, 0), m4(4, 3, 31, 1),
                    o4(13, 130, 255, 1), 1'b0};
        vecs[1] = '{e4(2, 10, 125, 1), d4(5, 100, 255, 0), m4(4, 3, 31, 1),
                    e4(2, 10, 125, 1), d4(5, 100, 255, 0), m4(4, 3, 31, 1),
                    o4(13, 130, 4095, 1), 1'b0};
        vecs[2] = '{e4(2, 10, 0, 1), d4(5, 100, 255, 0), m4(4, 3, 31, 1),
                    e4(0, 0, 0, 0), d4(7, 7, 7, 7), m4(0, 0, 0, 0),
                    o4(13, 130, 255, 1), 1'b0};
        vecs[3] = '{e4(0, 0, 0, 0), d4(7, 7, 7, 7), m4(0, 0, 0, 0),
                    e4(0, 0, 0, 0), d4(7, 7, 7, 7), m4(0, 0, 0, 0),
                    o4(7, 7, 7, 7), 1'b0};
        vecs[4] = '{e4(1, 2, 3, 4), d4(10, 20, 30, 40), m4(1, 1, 1, 1),
                    e4(1, 2, 3, 4), d4(10, 20, 30, 40), m4(1, 1, 1, 1),
                    o4(11, 22, 33, 44), 1'b1};
        vecs[5] = '{e4(127, 127, 127, 127), d4(255, 255, 255, 255), m4(31, 31, 31, 31),
                    e4(127, 127, 127, 127), d4(255, 255, 255, 255), m4(31, 31, 31, 31),
                    o4(4095, 4095, 4095, 4095), 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_dc_out", dc_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mix", {mix_env, mix_dc_pre, mix_mul}, 0);

        // Table-driven sweeps
        last_out = '0;
        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i], last_out);
            last_out = vecs[i].exp_out;
        end

        // START held high: back-to-back sweeps, new inputs picked up each time
        @(negedge clk);
        env_in = vecs[4].env_pre; dc_in = vecs[4].dc_pre; mul_in = vecs[4].mul_pre;
        start  = 1'b1;
        wait_done(c0, ok);
        check("b2b_done0", ok, 1);
        check("b2b_out0", dc_out, vecs[4].exp_out);
        env_in = vecs[0].env_pre; dc_in = vecs[0].dc_pre; mul_in = vecs[0].mul_pre;
        wait_done(c1, ok);
        check("b2b_done1", ok, 1);
        // Restart is accepted in the DONE cycle, so the DONE period is one sweep plus one.
        check("b2b_period1", c1 - c0, SWEEP + 1);
        check("b2b_out1", dc_out, vecs[0].exp_out);
        env_in = vecs[3].env_pre; dc_in = vecs[3].dc_pre; mul_in = vecs[3].mul_pre;
        wait_done(c2, ok);
        start = 1'b0;
        check("b2b_done2", ok, 1);
        check("b2b_period2", c2 - c1, SWEEP + 1);
        check("b2b_out2", dc_out, vecs[3].exp_out);
        repeat (SWEEP + 3) @(negedge clk);
        check("b2b_idle_busy", busy, 0);

        // Reset during DRAIN
        env_in = vecs[0].env_pre; dc_in = vecs[0].dc_pre; mul_in = vecs[0].mul_pre;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_dc_out", dc_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mix", {mix_env, mix_dc_pre, mix_mul}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int stray = 0;
            repeat (15) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            check("abort_no_done", stray, 0);
        end
        check("abort_dc_out_held", dc_out, 0);
        run_sweep(vecs[0], 48'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
